uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Frame controller for the UART receiver, directly downstream of the edge/bit counter and the data sampler. It enables the counter, follows the frame position from BIT_CNT/EDGE_CNT, and shifts sampled data bits into a parallel word. It also checks start, parity and stop bits, and emits the received byte with a one-cycle valid strobe and error flags. Frame format: 1 start bit, DATA_WIDTH data bits sent LSB first, optional parity bit, 1 stop bit.

Parameters:
WIDTH, 7, EDGE_CNT width; PRESCALE is WIDTH-1 bits wide; must match the counter instance.
DATA_WIDTH, 8, data bits per frame; legal range 5..8.

Ports:
CLK  in  1  system clock (oversampling clock)
RST  in  1  asynchronous active-low reset
RX_IN  in  1  serial line; idle high
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
PRESCALE  in  WIDTH-1  oversampling ratio; legal values 8, 16, 32; must be static while BUSY=1
BIT_CNT  in  4  frame bit index from the counter
EDGE_CNT  in  WIDTH  edge index within the current bit, from the counter
SAMPLED_BIT  in  1  majority-voted bit from the sampler; stable by EDGE_CNT = PRESCALE-1
EDGE_BIT_EN  out  1  counter enable
DAT_SAMP_EN  out  1  sampler enable
P_DATA  out  DATA_WIDTH  received word
DATA_VALID  out  1  one-cycle strobe; P_DATA is valid
PAR_ERR  out  1  parity mismatch on the last frame
STP_ERR  out  1  stop bit sampled as 0 on the last frame
STRT_GLITCH  out  1  one-cycle pulse; false start detected
BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE; all outputs 0; shift register 0; latched config 0.
- BIT_END = (state != IDLE) && (EDGE_CNT == PRESCALE-1). PRESCALE-1 is computed at WIDTH bits with zero-extension.
- EDGE_BIT_EN = DAT_SAMP_EN = BUSY = (state != IDLE). These three are combinational from the state register.
- Counter contract: when the enable is low, the counter holds 0/0. In the first enabled cycle the counter shows EDGE_CNT = 0, BIT_CNT = 0.
- IDLE: when RX_IN = 0, go to START next cycle. On the same edge, latch PAR_EN and PAR_TYP, and clear PAR_ERR and STP_ERR.
- START: at BIT_END, if SAMPLED_BIT = 1, pulse STRT_GLITCH for one cycle and go to IDLE. Otherwise go to DATA.
- DATA: at BIT_END, shift right with SAMPLED_BIT entering the MSB, so the first received bit lands in bit 0. When BIT_CNT = DATA_WIDTH, go to PARITY if latched PAR_EN = 1, else to STOP.
- PARITY: expected bit = XOR-reduce(shift register) XOR latched PAR_TYP. At BIT_END, set PAR_ERR = (SAMPLED_BIT != expected), then go to STOP.
- STOP: at BIT_END, set STP_ERR = ~SAMPLED_BIT. If the stop bit is 1 and PAR_ERR = 0, load P_DATA from the shift register and pulse DATA_VALID in the following cycle. Always go to IDLE.
- P_DATA changes only when DATA_VALID is loaded and holds otherwise. PAR_ERR and STP_ERR hold until the next start is detected.
- Back-to-back frames: IDLE lasts at least one cycle after STOP, which drops the enable and clears the counter. RX_IN is evaluated in that same cycle, so a start bit immediately following the stop bit is caught with a one-tick slip.
- RX_IN is not evaluated inside a frame except through SAMPLED_BIT.
- Asynchronous reset mid-frame returns to IDLE immediately with all outputs 0. No DATA_VALID is emitted for the aborted frame.
- A BIT_CNT value beyond the expected index in any state is treated as an error: go to IDLE without DATA_VALID.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_IDX = 0 and DATA_FIRST_IDX = 1;
  - legal PRESCALE values 8, 16, 32;
  - parity encoding constants PAR_EVEN = 0, PAR_ODD = 1.
- One natural sub-module: uart_rx_par_chk, combinational expected-parity calculation over the shift register and PAR_TYP.
- The FSM, shift register and error flags stay in uart_rx_ctrl.

Test Plan:
(The bench instantiates this block with the edge/bit counter and the sampler.)
- PRESCALE=8, PAR_EN=0, frame 0xA5 with stop=1 -> DATA_VALID high exactly 1 cycle, P_DATA=0xA5, PAR_ERR=STP_ERR=0, BUSY low afterwards.
- PRESCALE=8, PAR_EN=1, PAR_TYP=0, data 0x03 with parity 0 -> P_DATA=0x03, valid. Repeat with parity 1 -> PAR_ERR=1, no DATA_VALID, P_DATA still 0x03.
- PRESCALE=16, RX_IN low for 3 ticks then high -> STRT_GLITCH 1-cycle pulse at EDGE_CNT=15, return to IDLE, no DATA_VALID, P_DATA unchanged.
- PRESCALE=8, data 0x3C with stop bit 0 -> STP_ERR=1, no DATA_VALID. The next good frame 0x11 clears STP_ERR at start and yields P_DATA=0x11.
- PRESCALE=32, PAR_EN=1, PAR_TYP=1, back-to-back frames 0x55 then 0xAA with no idle gap -> two DATA_VALID pulses, P_DATA=0x55 then 0xAA, no errors.
- PRESCALE=8, RST asserted during DATA bit 4 -> all outputs 0 immediately. After release, a clean frame 0x7E yields P_DATA=0x7E.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// No logic here; latency and backpressure do not apply.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int START_IDX      = 0;
    localparam int DATA_FIRST_IDX = 1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_par_chk.sv
// Expected parity bit for the received word under even/odd parity.
// Purely combinational, zero latency; no flow control.
module uart_rx_par_chk #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  exp_par
);

    assign exp_par = (^data) ^ par_typ;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: tracks frame position, assembles the word, checks start/parity/stop.
// P_DATA/DATA_VALID one cycle after the stop-bit end; no backpressure, DATA_VALID is a strobe.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int WIDTH      = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [WIDTH-2:0]      PRESCALE,
    input  logic [3:0]            BIT_CNT,
    input  logic [WIDTH-1:0]      EDGE_CNT,
    input  logic                  SAMPLED_BIT,
    output logic                  EDGE_BIT_EN,
    output logic                  DAT_SAMP_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  STRT_GLITCH,
    output logic                  BUSY
);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic [WIDTH-1:0]        presc_m1;
    logic                    bit_end;
    logic                    exp_par;
    logic [3:0]              max_idx;
    logic                    bit_over;

    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_FIRST_IDX + DATA_WIDTH - 1);

    assign presc_m1    = {1'b0, PRESCALE} - WIDTH'(1);
    assign bit_end     = (state != IDLE) && (EDGE_CNT == presc_m1);
    assign BUSY        = (state != IDLE);
    assign EDGE_BIT_EN = BUSY;
    assign DAT_SAMP_EN = BUSY;

    uart_rx_par_chk #(.DATA_WIDTH(DATA_WIDTH)) u_par_chk (
        .data    (shreg),
        .par_typ (par_typ_q),
        .exp_par (exp_par)
    );

    // Highest bit index the counter may legally show in each state.
    always_comb begin
        max_idx = 4'(START_IDX);
        case (state)
            DATA:    max_idx = LAST_DATA_IDX;
            PARITY:  max_idx = LAST_DATA_IDX + 4'd1;
            STOP:    max_idx = LAST_DATA_IDX + 4'd1 + {3'b000, par_en_q};
            default: max_idx = 4'(START_IDX);
        endcase
    end

    assign bit_over = (state != IDLE) && (BIT_CNT > max_idx);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            shreg       <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            P_DATA      <= '0;
            DATA_VALID  <= 1'b0;
            PAR_ERR     <= 1'b0;
            STP_ERR     <= 1'b0;
            STRT_GLITCH <= 1'b0;
        end else begin
            DATA_VALID  <= 1'b0;
            STRT_GLITCH <= 1'b0;
            if (bit_over) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!RX_IN) begin
                            state     <= START;
                            par_en_q  <= PAR_EN;
                            par_typ_q <= PAR_TYP;
                            PAR_ERR   <= 1'b0;
                            STP_ERR   <= 1'b0;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            if (SAMPLED_BIT) begin
                                STRT_GLITCH <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            // LSB arrives first, so shifting right leaves it in bit 0.
                            shreg <= {SAMPLED_BIT, shreg[DATA_WIDTH-1:1]};
                            if (BIT_CNT == LAST_DATA_IDX) begin
                                state <= par_en_q ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            PAR_ERR <= (SAMPLED_BIT != exp_par);
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            STP_ERR <= ~SAMPLED_BIT;
                            if (SAMPLED_BIT && !PAR_ERR) begin
                                P_DATA     <= shreg;
                                DATA_VALID <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
